// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives IF/ID and ID/EX enables, bubbles and flushes
// from RAW hazards, taken branches and memory-busy freezes; keeps stall/flush counters.
module hazard_ctrl #(
    parameter bit          FWD_EN = 1'b0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic [2:0]       ex_w_reg,
    input  logic             ex_reg_w_en,
    input  logic             ex_read_mem,
    input  logic [2:0]       mem_w_reg,
    input  logic             mem_reg_w_en,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FREEZE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   ex_hit;
    logic   mem_hit;
    logic   haz;
    logic   stall_inc;
    logic   flush_inc;

    // RAW match of decode sources against the EX and MEM writers; R0 is not exempt.
    always_comb begin
        ex_hit  = ex_reg_w_en  & ((id_rs_used & (id_rs == ex_w_reg))
                               | (id_rt_used & (id_rt == ex_w_reg)));
        mem_hit = mem_reg_w_en & ((id_rs_used & (id_rs == mem_w_reg))
                               | (id_rt_used & (id_rt == mem_w_reg)));
        haz     = FWD_EN ? (ex_hit & ex_read_mem) : (ex_hit | mem_hit);
    end

    // Priority decode: rst > mem_busy > taken branch > hazard > run.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        state_d      = ST_RUN;
        if (rst) begin
            // NOPs fill the pipe while reset is held
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            state_d  = ST_FREEZE;
        end else if (ex_branch_taken) begin
            // decode holds a wrong-path instruction, so any hazard is moot
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            state_d      = ST_FLUSH;
        end else if (haz) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            state_d      = ST_STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: u_d0 has no forwarding (16-bit counters), u_d1 forwards and
// uses 4-bit counters so saturation is reachable in a short run.
module tb_hazard_ctrl;

    localparam logic [4:0] O_RST  = 5'b11111; // {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_bubble}
    localparam logic [4:0] O_RUN  = 5'b11010;
    localparam logic [4:0] O_HAZ  = 5'b00011;
    localparam logic [4:0] O_TAKE = 5'b11111;
    localparam logic [4:0] O_FRZ  = 5'b00000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_w_reg, mem_w_reg;
    logic       id_rs_used, id_rt_used, ex_reg_w_en, ex_read_mem, mem_reg_w_en;
    logic       ex_branch_taken, mem_busy;

    logic        pc_en0, if_id_en0, if_id_flush0, id_ex_en0, id_ex_bubble0;
    logic [1:0]  state0;
    logic [15:0] stall_cnt0, flush_cnt0;
    logic        pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_bubble1;
    logic [1:0]  state1;
    logic [3:0]  stall_cnt1, flush_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) u_d0 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .ex_w_reg(ex_w_reg), .ex_reg_w_en(ex_reg_w_en), .ex_read_mem(ex_read_mem),
        .mem_w_reg(mem_w_reg), .mem_reg_w_en(mem_reg_w_en),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en0), .if_id_en(if_id_en0), .if_id_flush(if_id_flush0),
        .id_ex_en(id_ex_en0), .id_ex_bubble(id_ex_bubble0),
        .state(state0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(4)) u_d1 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .ex_w_reg(ex_w_reg), .ex_reg_w_en(ex_reg_w_en), .ex_read_mem(ex_read_mem),
        .mem_w_reg(mem_w_reg), .mem_reg_w_en(mem_reg_w_en),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en1), .if_id_en(if_id_en1), .if_id_flush(if_id_flush1),
        .id_ex_en(id_ex_en1), .id_ex_bubble(id_ex_bubble1),
        .state(state1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    wire [4:0] outs0 = {pc_en0, if_id_en0, if_id_flush0, id_ex_en0, id_ex_bubble0};
    wire [4:0] outs1 = {pc_en1, if_id_en1, if_id_flush1, id_ex_en1, id_ex_bubble1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 3'd0; id_rs_used = 1'b0; id_rt = 3'd0; id_rt_used = 1'b0;
        ex_w_reg = 3'd0; ex_reg_w_en = 1'b0; ex_read_mem = 1'b0;
        mem_w_reg = 3'd0; mem_reg_w_en = 1'b0;
        ex_branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        chk("rst_outs0", 32'(outs0), 32'(O_RST));
        chk("rst_state0", 32'(state0), 32'd0);
        chk("rst_stall0", 32'(stall_cnt0), 32'd0);
        chk("rst_flush0", 32'(flush_cnt0), 32'd0);
        tick();
        rst = 1'b0;

        // no hazard: writer disabled
        id_rs = 3'd3; id_rs_used = 1'b1; ex_w_reg = 3'd3;
        #1;
        chk("run_outs0", 32'(outs0), 32'(O_RUN));
        chk("run_outs1", 32'(outs1), 32'(O_RUN));
        tick();
        chk("run_state0", 32'(state0), 32'd0);

        // EX hit, no load: stalls only without forwarding
        ex_reg_w_en = 1'b1;
        #1;
        chk("exhit_outs0", 32'(outs0), 32'(O_HAZ));
        chk("exhit_outs1", 32'(outs1), 32'(O_RUN));
        tick();
        chk("exhit_state0", 32'(state0), 32'd1);
        chk("exhit_stall0", 32'(stall_cnt0), 32'd1);
        chk("exhit_stall1", 32'(stall_cnt1), 32'd0);

        // writer moves to MEM: second stall cycle for no-forwarding
        ex_reg_w_en = 1'b0; mem_reg_w_en = 1'b1; mem_w_reg = 3'd3;
        #1;
        chk("memhit_outs0", 32'(outs0), 32'(O_HAZ));
        chk("memhit_outs1", 32'(outs1), 32'(O_RUN));
        tick();
        chk("memhit_stall0", 32'(stall_cnt0), 32'd2);
        chk("memhit_state0", 32'(state0), 32'd1);
        mem_reg_w_en = 1'b0;
        #1;
        chk("resume_outs0", 32'(outs0), 32'(O_RUN));
        tick();
        chk("resume_state0", 32'(state0), 32'd0);

        // load-use via rt: both stall once, forwarding releases after one cycle
        clear_inputs();
        id_rt = 3'd5; id_rt_used = 1'b1; ex_w_reg = 3'd5; ex_reg_w_en = 1'b1; ex_read_mem = 1'b1;
        #1;
        chk("ld_outs0", 32'(outs0), 32'(O_HAZ));
        chk("ld_outs1", 32'(outs1), 32'(O_HAZ));
        tick();
        chk("ld_state1", 32'(state1), 32'd1);
        chk("ld_stall1", 32'(stall_cnt1), 32'd1);
        ex_reg_w_en = 1'b0; ex_read_mem = 1'b0; mem_reg_w_en = 1'b1; mem_w_reg = 3'd5;
        #1;
        chk("ld2_outs0", 32'(outs0), 32'(O_HAZ));
        chk("ld2_outs1", 32'(outs1), 32'(O_RUN));
        tick();
        chk("ld2_stall0", 32'(stall_cnt0), 32'd4);
        chk("ld2_state1", 32'(state1), 32'd0);

        // R0 is a normal register
        clear_inputs();
        id_rs_used = 1'b1; ex_reg_w_en = 1'b1;
        #1;
        chk("r0_outs0", 32'(outs0), 32'(O_HAZ));
        tick();
        chk("r0_stall0", 32'(stall_cnt0), 32'd5);

        // taken branch beats a simultaneous load-use hazard
        clear_inputs();
        id_rs = 3'd3; id_rs_used = 1'b1; ex_w_reg = 3'd3; ex_reg_w_en = 1'b1; ex_read_mem = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        chk("take_outs0", 32'(outs0), 32'(O_TAKE));
        chk("take_outs1", 32'(outs1), 32'(O_TAKE));
        tick();
        chk("take_state0", 32'(state0), 32'd2);
        chk("take_flush0", 32'(flush_cnt0), 32'd1);
        chk("take_stall0", 32'(stall_cnt0), 32'd5);
        chk("take_stall1", 32'(stall_cnt1), 32'd1);

        // freeze for 3 cycles over a hazard, then the stall resumes
        clear_inputs();
        id_rs = 3'd2; id_rs_used = 1'b1; ex_w_reg = 3'd2; ex_reg_w_en = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_outs0", 32'(outs0), 32'(O_FRZ));
            tick();
            chk("frz_state0", 32'(state0), 32'd3);
            chk("frz_stall0", 32'(stall_cnt0), 32'd5);
        end
        mem_busy = 1'b0;
        #1;
        chk("unfrz_outs0", 32'(outs0), 32'(O_HAZ));
        tick();
        chk("unfrz_state0", 32'(state0), 32'd1);
        chk("unfrz_stall0", 32'(stall_cnt0), 32'd6);

        // saturation of the 4-bit counters
        ex_read_mem = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("sat_stall1", 32'(stall_cnt1), 32'hF);
        tick();
        chk("sat_hold_stall1", 32'(stall_cnt1), 32'hF);
        chk("sat_outs1", 32'(outs1), 32'(O_HAZ));
        chk("nosat_stall0", 32'(stall_cnt0), 32'd23);
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("sat_flush1", 32'(flush_cnt1), 32'hF);
        chk("nosat_flush0", 32'(flush_cnt0), 32'd17);
        chk("sat_stall_keep1", 32'(stall_cnt1), 32'hF);

        // async reset mid-stall
        ex_branch_taken = 1'b0;
        tick();
        chk("prerst_state0", 32'(state0), 32'd1);
        chk("prerst_stall0", 32'(stall_cnt0), 32'd24);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state0", 32'(state0), 32'd0);
        chk("arst_stall0", 32'(stall_cnt0), 32'd0);
        chk("arst_flush0", 32'(flush_cnt0), 32'd0);
        chk("arst_stall1", 32'(stall_cnt1), 32'd0);
        chk("arst_outs0", 32'(outs0), 32'(O_RST));
        tick();
        chk("arst_hold_outs1", 32'(outs1), 32'(O_RST));
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("post_outs0", 32'(outs0), 32'(O_RUN));
        tick();
        chk("post_state0", 32'(state0), 32'd0);
        chk("post_stall0", 32'(stall_cnt0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
